// File: rtl/tone_pkg.sv
// tone_pkg: constants shared by the tone detector.
//   HP_TABLE    - generator half-period counts (in MHz units) per note
//   NOTE_*      - note index codes, 0=C3 .. 7=C4
//   TOL_SHIFT   - match tolerance is P[k] >> TOL_SHIFT
//   state_e     - detector FSM encoding
//   note_period - full period in clk cycles for note k at base clock m MHz
package tone_pkg;

   localparam int NUM_NOTES = 8;
   localparam int TOL_SHIFT = 5;

   localparam logic [2:0] NOTE_C3 = 3'd0;
   localparam logic [2:0] NOTE_D3 = 3'd1;
   localparam logic [2:0] NOTE_E3 = 3'd2;
   localparam logic [2:0] NOTE_F3 = 3'd3;
   localparam logic [2:0] NOTE_G3 = 3'd4;
   localparam logic [2:0] NOTE_A3 = 3'd5;
   localparam logic [2:0] NOTE_B3 = 3'd6;
   localparam logic [2:0] NOTE_C4 = 3'd7;

   localparam int unsigned HP_TABLE [NUM_NOTES] =
      '{1911, 1703, 1517, 1432, 1270, 1136, 1012, 956};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FIRST   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_LOCKED  = 2'd3
   } state_e;

   // A generator that toggles each time its counter reaches m*HP spends
   // m*HP+1 cycles per half, hence the +1 before doubling.
   function automatic int unsigned note_period(input int unsigned m, input logic [2:0] k);
      return 2 * (m * HP_TABLE[k] + 1);
   endfunction

endpackage

// File: rtl/tone_period_match.sv
// tone_period_match: combinational classifier of a measured period.
//   period - measured full period in clk cycles
//   match  - period lies within P[k] +/- (P[k] >> TOL_SHIFT) for some note
//   k      - lowest matching note index (0 when no match)
module tone_period_match
   import tone_pkg::*;
#(
   parameter int M = 20,
   parameter int N = 20
) (
   input  logic [N:0] period,
   output logic       match,
   output logic [2:0] k
);

   logic [31:0] per_w;
   assign per_w = 32'(period);

   always_comb begin
      logic [31:0] p_ref;
      logic [31:0] diff;
      p_ref = '0;
      diff  = '0;
      match = 1'b0;
      k     = '0;
      // Scan from the top down so the lowest matching index is written last.
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         p_ref = note_period(M, 3'(i));
         diff  = (per_w >= p_ref) ? (per_w - p_ref) : (p_ref - per_w);
         if (diff <= (p_ref >> TOL_SHIFT)) begin
            match = 1'b1;
            k     = 3'(i);
         end
      end
   end

endmodule

// File: rtl/tone_detector.sv
// tone_detector: locks onto a square-wave tone and reports which note it is.
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high
//   tone_in     - asynchronous square wave
//   note_code   - detected note index (0=C3 .. 7=C4)
//   note_valid  - high while a note is locked
//   note_change - one-cycle pulse on lock or on a confirmed note change
//   period      - last measured full period in clk cycles
// Optional build macro TONE_GLITCH_FILTER_EN: debounces the synchronized
// input so short pulses never reach edge detection (3 extra cycles latency).
module tone_detector
   import tone_pkg::*;
#(
   parameter int M = 20,
   parameter int N = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tone_in,
   output logic [2:0] note_code,
   output logic       note_valid,
   output logic       note_change,
   output logic [N:0] period
);

   localparam logic [N:0]  CNT_MAX    = '1;
   localparam logic [N:0]  MIN_PERIOD = (N+1)'(4);
   localparam int unsigned TIMEOUT    = 2 * note_period(M, NOTE_C3);

   logic       sync1_q, sync2_q;
   logic       sig, sig_prev_q, rise;
   state_e     state_q, state_d;
   logic [N:0] cnt_q, cnt_d;
   logic [N:0] period_q, period_d, meas_period;
   logic [2:0] cand_q, cand_d;
   logic       cand_vld_q, cand_vld_d;
   logic [2:0] note_code_q, note_code_d;
   logic       note_valid_q, note_valid_d;
   logic       note_change_q, note_change_d;
   logic       pm_match, match_ok, timeout_hit;
   logic [2:0] pm_k;

`ifdef TONE_GLITCH_FILTER_EN
   // The filtered level follows sync2 only after sync2 has disagreed with
   // it for three cycles running; anything shorter is dropped.
   logic       filt_q, filt_d;
   logic [1:0] run_q, run_d;

   always_comb begin
      filt_d = filt_q;
      run_d  = 2'd0;
      if (sync2_q != filt_q) begin
         if (run_q == 2'd2) filt_d = sync2_q;
         else               run_d  = run_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q <= 1'b0;
         run_q  <= 2'd0;
      end else begin
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign sig = filt_q;
`else
   assign sig = sync2_q;
`endif

   assign rise        = sig & ~sig_prev_q;
   // Counter never wraps, so a saturated count reports a saturated period.
   assign meas_period = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign timeout_hit = (32'(cnt_q) >= TIMEOUT);
   // Edges closer than MIN_PERIOD cycles are treated as noise.
   assign match_ok    = pm_match && (meas_period >= MIN_PERIOD);

   tone_period_match #(.M(M), .N(N)) u_match (
      .period (meas_period),
      .match  (pm_match),
      .k      (pm_k)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      period_d      = period_q;
      cand_d        = cand_q;
      cand_vld_d    = cand_vld_q;
      note_code_d   = note_code_q;
      note_valid_d  = note_valid_q;
      note_change_d = 1'b0;

      if (state_q == ST_IDLE) begin
         cnt_d = '0;
         if (rise) state_d = ST_FIRST;
      end else if (timeout_hit) begin
         state_d      = ST_IDLE;
         cnt_d        = '0;
         cand_vld_d   = 1'b0;
         note_valid_d = 1'b0;
      end else if (rise) begin
         cnt_d      = '0;
         period_d   = meas_period;
         cand_d     = pm_k;
         cand_vld_d = match_ok;
         case (state_q)
            ST_FIRST: state_d = ST_MEASURE;
            ST_MEASURE: begin
               // Two consecutive periods agreeing on one note confirm it.
               if (match_ok && cand_vld_q && (pm_k == cand_q)) begin
                  state_d       = ST_LOCKED;
                  note_valid_d  = 1'b1;
                  note_code_d   = pm_k;
                  note_change_d = !note_valid_q || (pm_k != note_code_q);
               end
            end
            ST_LOCKED: begin
               // A different note keeps the old lock reported until confirmed;
               // an unrecognised period drops the lock immediately.
               if (!(match_ok && (pm_k == note_code_q))) begin
                  state_d = ST_MEASURE;
                  if (!match_ok) note_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         sig_prev_q    <= 1'b0;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         period_q      <= '0;
         cand_q        <= '0;
         cand_vld_q    <= 1'b0;
         note_code_q   <= '0;
         note_valid_q  <= 1'b0;
         note_change_q <= 1'b0;
      end else begin
         sync1_q       <= tone_in;
         sync2_q       <= sync1_q;
         sig_prev_q    <= sig;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         period_q      <= period_d;
         cand_q        <= cand_d;
         cand_vld_q    <= cand_vld_d;
         note_code_q   <= note_code_d;
         note_valid_q  <= note_valid_d;
         note_change_q <= note_change_d;
      end
   end

   assign note_code   = note_code_q;
   assign note_valid  = note_valid_q;
   assign note_change = note_change_q;
   assign period      = period_q;

endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed bench for tone_detector at M=1, where
// P[k] = 2*(HP[k]+1): C3=3824 B3=2026 C4=1914 G3=2542, timeout 7648.
module tb_tone_detector;
   import tone_pkg::*;

`ifdef TONE_GLITCH_FILTER_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 3;
`endif

   logic        clk;
   logic        reset;
   logic        tone_in;
   logic [2:0]  note_code;
   logic        note_valid;
   logic        note_change;
   logic [20:0] period;

   int checks = 0;
   int errors = 0;
   int chg_cnt = 0;
   int c0;

   tone_detector #(.M(1), .N(20)) dut (
      .clk         (clk),
      .reset       (reset),
      .tone_in     (tone_in),
      .note_code   (note_code),
      .note_valid  (note_valid),
      .note_change (note_change),
      .period      (period)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (note_change === 1'b1) chg_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full period of p cycles starting with a rising pin edge; pre cycles
   // of the high half have already been spent.
   task automatic per(input int p, input int pre);
      tone_in = 1'b1;
      tick(p / 2 - pre);
      tone_in = 1'b0;
      tick(p - p / 2);
   endtask

   initial begin
      reset   = 1'b1;
      tone_in = 1'b0;
      tick(3);
      check("rst_code",   32'(note_code),   0);
      check("rst_valid",  32'(note_valid),  0);
      check("rst_change", 32'(note_change), 0);
      check("rst_period", 32'(period),      0);
      check("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
      reset = 1'b0;
      tick(2);

      // G3 locks on the third rising edge, LAT cycles after the pin.
      per(2542, 0);
      per(2542, 0);
      tone_in = 1'b1;
      tick(LAT - 1);
      check("g3_pre_valid", 32'(note_valid), 0);
      tick(1);
      check("g3_valid",  32'(note_valid),  1);
      check("g3_code",   32'(note_code),   4);
      check("g3_change", 32'(note_change), 1);
      check("g3_period", 32'(period),      2542);
      tick(1);
      check("g3_change_end", 32'(note_change), 0);

      // Reset in the middle of a lock.
      reset   = 1'b1;
      tone_in = 1'b0;
      tick(1);
      check("mid_rst_code",   32'(note_code),   0);
      check("mid_rst_valid",  32'(note_valid),  0);
      check("mid_rst_change", 32'(note_change), 0);
      check("mid_rst_period", 32'(period),      0);
      check("mid_rst_state",  32'(dut.state_q), 32'(ST_IDLE));
      tick(1);
      reset = 1'b0;
      tick(2);
      per(2542, 0);
      per(2542, 0);
      tone_in = 1'b1;
      tick(LAT - 1);
      check("relock_pre_valid", 32'(note_valid), 0);
      tick(1);
      check("relock_valid",  32'(note_valid),  1);
      check("relock_code",   32'(note_code),   4);
      check("relock_change", 32'(note_change), 1);

      // Switch G3 -> C3: old note stays valid until C3 is confirmed.
      per(2542, LAT);
      c0 = chg_cnt;
      per(3824, 0);
      check("sw1_valid", 32'(note_valid), 1);
      check("sw1_code",  32'(note_code),  4);
      per(3824, 0);
      check("sw2_valid", 32'(note_valid), 1);
      check("sw2_code",  32'(note_code),  4);
      tone_in = 1'b1;
      tick(LAT);
      check("c3_code",   32'(note_code),   0);
      check("c3_valid",  32'(note_valid),  1);
      check("c3_period", 32'(period),      3824);
      tick(1);
      check("c3_pulses", 32'(chg_cnt - c0), 1);

      // Tone stops: still locked before 2*P[0], idle after.
      tick(1912 - LAT - 1);
      tone_in = 1'b0;
      tick(5000);
      check("to_pre_valid", 32'(note_valid),  1);
      check("to_pre_state", 32'(dut.state_q), 32'(ST_LOCKED));
      tick(2700);
      check("to_valid", 32'(note_valid),  0);
      check("to_state", 32'(dut.state_q), 32'(ST_IDLE));

      // 3944 = C3 + tol + 1: no match, but period still reported.
      per(3944, 0);
      per(3944, 0);
      tone_in = 1'b1;
      tick(LAT);
      check("nm_valid",  32'(note_valid),  0);
      check("nm_period", 32'(period),      3944);
      check("nm_state",  32'(dut.state_q), 32'(ST_MEASURE));

      // 3943 = C3 + tol: matches C3.
      per(3943, LAT);
      per(3943, 0);
      tone_in = 1'b1;
      tick(LAT);
      check("tol_valid",  32'(note_valid), 1);
      check("tol_code",   32'(note_code),  0);
      check("tol_period", 32'(period),     3943);

      // 1970 is inside both B3 and C4 windows: B3 (lower index) wins.
      per(1970, LAT);
      per(1970, 0);
      check("ov_mid_valid", 32'(note_valid), 1);
      check("ov_mid_code",  32'(note_code),  0);
      tone_in = 1'b1;
      tick(LAT);
      check("ov_code",   32'(note_code),   6);
      check("ov_valid",  32'(note_valid),  1);
      check("ov_change", 32'(note_change), 1);

      // Two-cycle glitch in the low half, then an edge 3 cycles later.
      tick(985 - LAT);
      tone_in = 1'b0;
      tick(200);
      tone_in = 1'b1;
      tick(2);
      tone_in = 1'b0;
      tick(1);
`ifdef TONE_GLITCH_FILTER_EN
      check("gl_valid",  32'(note_valid), 1);
      check("gl_period", 32'(period),     1970);
`else
      check("gl_valid",  32'(note_valid), 0);
      check("gl_period", 32'(period),     1185);
      tone_in = 1'b1;
      tick(LAT);
      check("short_period", 32'(period),     3);
      check("short_valid",  32'(note_valid), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
